// File: rtl/buzzer_beep_driver_pkg.sv
// Shared constants for the buzzer beep driver: FSM state encoding and
// default 25 MHz timing (100 ms beep, 100 ms gap, 1 kHz tone).
package buzzer_beep_driver_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    localparam int unsigned DEF_ON_CYCLES   = 2_500_000;
    localparam int unsigned DEF_OFF_CYCLES  = 2_500_000;
    localparam int unsigned DEF_CNT_WIDTH   = 22;
    localparam int unsigned DEF_COUNT_WIDTH = 4;
    localparam int unsigned DEF_TONE_HALF   = 12_500;

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator for a passive buzzer. The output is registered,
// starts high on the cycle after restart_i and toggles every TONE_HALF enabled
// cycles; it is forced low whenever en_i is low.
module buzzer_tone_gen #(
    parameter int unsigned TONE_HALF = 12_500
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic en_i,
    output logic tone_o
);

    localparam int unsigned TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tone_q, tone_d;

    // Next tone phase: restart high, toggle at half-period, silent when disabled.
    always_comb begin
        tcnt_d = tcnt_q;
        tone_d = tone_q;
        if (restart_i) begin
            tcnt_d = '0;
            tone_d = 1'b1;
        end else if (!en_i) begin
            tcnt_d = '0;
            tone_d = 1'b0;
        end else if (tcnt_q == TW'(TONE_HALF - 1)) begin
            tcnt_d = '0;
            tone_d = ~tone_q;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // Tone state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
            tone_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = tone_q;

endmodule

// File: rtl/buzzer_beep_driver.sv
// Buzzer/LED beep-train driver: turns a one-cycle start pulse into N timed
// beeps with busy/done handshake and abort. Reset input rst_n is synchronous
// and active-high. Optional macro BUZZER_TONE_EN selects a square-wave tone
// during beeps (passive buzzer) instead of a steady high drive.
module buzzer_beep_driver
    import buzzer_beep_driver_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES  = DEF_OFF_CYCLES,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int unsigned TONE_HALF   = DEF_TONE_HALF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] beep_count,
    input  logic                   stop,
    output logic                   busy,
    output logic                   done,
    output logic                   drive
);

    // Reject degenerate timing at elaboration.
    if (ON_CYCLES == 0 || OFF_CYCLES == 0 || TONE_HALF == 0) begin : g_bad_cfg
        $error("buzzer_beep_driver: ON_CYCLES, OFF_CYCLES and TONE_HALF must be >= 1");
    end

    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Next-state logic: phase counting, beep bookkeeping and abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (beep_count != '0) begin
                        rem_d   = beep_count;
                        cnt_d   = '0;
                        state_d = S_ON;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (cnt_q == CNT_WIDTH'(ON_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (rem_q == COUNT_WIDTH'(1)) begin
                        rem_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rem_d   = rem_q - COUNT_WIDTH'(1);
                        state_d = S_OFF;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_OFF: begin
                if (cnt_q == CNT_WIDTH'(OFF_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rem_d   = '0;
            end
        endcase
        // Abort wins over everything, including a simultaneous start in IDLE.
        if (stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rem_d   = '0;
            done_d  = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and handshake registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef BUZZER_TONE_EN
    logic tone_restart_c;
    logic tone_en_c;

    // Tone restarts on every ON entry and runs only while ON.
    assign tone_restart_c = (state_d == S_ON) && (state_q != S_ON) && !rst_n;
    assign tone_en_c      = (state_d == S_ON);

    buzzer_tone_gen #(
        .TONE_HALF (TONE_HALF)
    ) u_tone (
        .clk       (clk),
        .rst       (rst_n),
        .restart_i (tone_restart_c),
        .en_i      (tone_en_c),
        .tone_o    (drive)
    );
`else
    logic drive_q;

    // Steady drive for the whole ON phase.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            drive_q <= 1'b0;
        end else begin
            drive_q <= (state_d == S_ON);
        end
    end

    assign drive = drive_q;
`endif

endmodule

// File: tb/tb_buzzer_beep_driver.sv
// Self-checking bench for buzzer_beep_driver. Each scenario pushes the expected
// per-cycle (busy, drive, done) trace into a scoreboard queue and pops it one
// entry per clock as the DUT runs. Honors BUZZER_TONE_EN for the drive pattern.
module tb_buzzer_beep_driver;

    localparam int unsigned ON_C  = 4;
    localparam int unsigned OFF_C = 3;
    localparam int unsigned TH    = 1;
    localparam int unsigned CW    = 4;

    typedef struct packed {
        logic busy;
        logic drive;
        logic done;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] beep_count;
    logic          stop;
    logic          busy;
    logic          done;
    logic          drive;

    int   checks;
    int   errors;
    exp_t exp_q[$];

    buzzer_beep_driver #(
        .ON_CYCLES   (ON_C),
        .OFF_CYCLES  (OFF_C),
        .CNT_WIDTH   (3),
        .COUNT_WIDTH (CW),
        .TONE_HALF   (TH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .beep_count (beep_count),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .drive      (drive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pad level in the j-th cycle of a beep.
    function automatic logic exp_drive(int j);
`ifdef BUZZER_TONE_EN
        return ((j / TH) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic push_on(int n);
        for (int j = 0; j < n; j++) exp_q.push_back('{busy: 1'b1, drive: exp_drive(j), done: 1'b0});
    endtask

    task automatic push_off(int n);
        for (int j = 0; j < n; j++) exp_q.push_back('{busy: 1'b1, drive: 1'b0, done: 1'b0});
    endtask

    task automatic push_idle(int n);
        for (int j = 0; j < n; j++) exp_q.push_back('{busy: 1'b0, drive: 1'b0, done: 1'b0});
    endtask

    task automatic push_done();
        exp_q.push_back('{busy: 1'b0, drive: 1'b0, done: 1'b1});
    endtask

    // Full normal train of n beeps ending with its done cycle.
    task automatic push_train(int n);
        for (int i = 0; i < n; i++) begin
            push_on(ON_C);
            if (i < n - 1) push_off(OFF_C);
        end
        push_done();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, drive, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset: busy/drive/done=%b required 000", {busy, drive, done});
        end
        rst_n = 1'b0;
        push_idle(2);
        while (exp_q.size() != 0) begin
            exp_t e;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({busy, drive, done} !== e) begin
                errors++;
                $display("FAIL reset_idle: busy/drive/done=%b required %b", {busy, drive, done}, e);
            end
        end
    endtask

    task automatic test_three_beeps();
        int cyc = 0;
        push_train(3);
        push_idle(2);
        start = 1'b1; beep_count = CW'(3);
        while (exp_q.size() != 0) begin
            exp_t e;
            @(posedge clk); #1; cyc++;
            start = 1'b0; beep_count = CW'(9);
            e = exp_q.pop_front();
            checks++;
            if ({busy, drive, done} !== e) begin
                errors++;
                $display("FAIL three_beeps cyc %0d: busy/drive/done=%b required %b", cyc, {busy, drive, done}, e);
            end
        end
    endtask

    task automatic test_zero_count();
        int cyc = 0;
        push_done();
        push_idle(2);
        start = 1'b1; beep_count = CW'(0);
        while (exp_q.size() != 0) begin
            exp_t e;
            @(posedge clk); #1; cyc++;
            start = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({busy, drive, done} !== e) begin
                errors++;
                $display("FAIL zero_count cyc %0d: busy/drive/done=%b required %b", cyc, {busy, drive, done}, e);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc = 0;
        push_train(2);
        push_idle(3);
        start = 1'b1; beep_count = CW'(2);
        while (exp_q.size() != 0) begin
            exp_t e;
            @(posedge clk); #1; cyc++;
            if (cyc == 3) begin
                start = 1'b1; beep_count = CW'(5);
            end else begin
                start = 1'b0;
            end
            e = exp_q.pop_front();
            checks++;
            if ({busy, drive, done} !== e) begin
                errors++;
                $display("FAIL start_while_busy cyc %0d: busy/drive/done=%b required %b", cyc, {busy, drive, done}, e);
            end
        end
    endtask

    task automatic test_stop();
        int cyc = 0;
        // 3-beep train aborted during the 2nd cycle of the first gap, then a fresh 1-beep train.
        push_on(ON_C);
        push_off(2);
        push_idle(3);
        push_train(1);
        push_idle(1);
        start = 1'b1; beep_count = CW'(3);
        while (exp_q.size() != 0) begin
            exp_t e;
            @(posedge clk); #1; cyc++;
            start = 1'b0;
            stop  = (cyc == 6);
            if (cyc == 9) begin
                start = 1'b1; beep_count = CW'(1);
            end
            e = exp_q.pop_front();
            checks++;
            if ({busy, drive, done} !== e) begin
                errors++;
                $display("FAIL stop cyc %0d: busy/drive/done=%b required %b", cyc, {busy, drive, done}, e);
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        // Second start issued in the done cycle; then start+stop in IDLE is dropped.
        push_train(1);
        push_train(2);
        push_idle(4);
        start = 1'b1; beep_count = CW'(1);
        while (exp_q.size() != 0) begin
            exp_t e;
            @(posedge clk); #1; cyc++;
            start = 1'b0; stop = 1'b0;
            if (cyc == ON_C + 1) begin
                start = 1'b1; beep_count = CW'(2);
            end
            if (cyc == 2 * ON_C + OFF_C + ON_C + 3) begin
                start = 1'b1; stop = 1'b1; beep_count = CW'(3);
            end
            e = exp_q.pop_front();
            checks++;
            if ({busy, drive, done} !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: busy/drive/done=%b required %b", cyc, {busy, drive, done}, e);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_single_and_reset();
        int cyc = 0;
        // One beep (tone pattern when enabled), then reset in the 2nd ON cycle of a new train.
        push_train(1);
        push_idle(1);
        push_on(2);
        push_idle(3);
        start = 1'b1; beep_count = CW'(1);
        while (exp_q.size() != 0) begin
            exp_t e;
            @(posedge clk); #1; cyc++;
            start = 1'b0;
            rst_n = 1'b0;
            if (cyc == ON_C + 2) begin
                start = 1'b1; beep_count = CW'(2);
            end
            if (cyc == ON_C + 4) rst_n = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if ({busy, drive, done} !== e) begin
                errors++;
                $display("FAIL single_and_reset cyc %0d: busy/drive/done=%b required %b", cyc, {busy, drive, done}, e);
            end
        end
        rst_n = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        beep_count = '0;
        test_reset();
        test_three_beeps();
        test_zero_count();
        test_start_while_busy();
        test_stop();
        test_back_to_back();
        test_single_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_beep_driver.md
# buzzer_beep_driver

Output-side counterpart to the key debouncers: converts a one-cycle request pulse into a timed train of N beeps on a physical buzzer/LED pin. Sits between the control FSM, which issues `start` together with a beep count, and the top-level output pad. It reports `busy` while the train is playing and `done` when it finishes, and it can be aborted at any time.

## Interface
- `ON_CYCLES`, 2_500_000: drive-active length of one beep in clk cycles (100 ms at 25 MHz); ≥1
- `OFF_CYCLES`, 2_500_000: silent gap between consecutive beeps in clk cycles; ≥1
- `CNT_WIDTH`, 22: phase counter width; must hold max(ON_CYCLES, OFF_CYCLES)-1
- `COUNT_WIDTH`, 4: width of `beep_count`
- `TONE_HALF`, 12_500: tone half-period in clk cycles (1 kHz at 25 MHz); used only with `BUZZER_TONE_EN`
- `clk`  in  1  system clock, 25 MHz
- `rst_n`  in  1  reset; synchronous, active-high (asserted = 1, sampled on `posedge clk`)
- `start`  in  1  one-cycle request; sampled only in IDLE
- `beep_count`  in  COUNT_WIDTH  number of beeps; latched when `start` is accepted
- `stop`  in  1  abort request; takes effect in any state
- `busy`  out  1  high while in ON or OFF
- `done`  out  1  one-cycle pulse when a train completes normally
- `drive`  out  1  buzzer/LED pad drive, registered

## Operation
- FSM states: IDLE, ON, OFF. Phase counter `cnt` (CNT_WIDTH bits) and remaining-beep register `rem` (COUNT_WIDTH bits).
- IDLE: if `start` = 1, `stop` = 0 and `beep_count` ≠ 0, latch `rem` = `beep_count`, clear `cnt`, go to ON. If `start` = 1, `stop` = 0 and `beep_count` = 0, stay in IDLE and pulse `done` on the next cycle. Later changes on `beep_count` have no effect.
- ON: `cnt` increments each cycle. When `cnt` = ON_CYCLES-1:
  - if `rem` = 1, go to IDLE and pulse `done`;
  - otherwise decrement `rem`, clear `cnt` and go to OFF.
- OFF: `cnt` increments. When `cnt` = OFF_CYCLES-1, clear `cnt` and go to ON.
- `start` while busy is ignored; no queueing.
- `stop` = 1 in ON or OFF: next state is IDLE, `drive` goes to 0, `done` is not pulsed, and `rem` and `cnt` are cleared. `start` and `stop` together in IDLE: `stop` wins and the request is dropped.
- `rst_n` asserted mid-train: the same effect as `stop`, with all outputs 0 on the next edge.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `drive` = 0, `cnt` = 0, `rem` = 0.
- `start` accepted at edge k:
  - `busy` and `drive` go high from cycle k+1;
  - `drive` is high for exactly ON_CYCLES cycles per beep and low for exactly OFF_CYCLES cycles per gap.
- For N beeps, `busy` is high for N·ON_CYCLES + (N-1)·OFF_CYCLES cycles. `done` is high in the first cycle after the last ON cycle, and `busy` = 0 in that same cycle.
- A new `start` is accepted in the cycle where `done` = 1, because the FSM is already in IDLE. Back-to-back trains therefore have zero idle gap beyond the `done` cycle.
- The `done` pulse for `beep_count` = 0 arrives 1 cycle after `start`; `busy` stays 0.
- `stop` latency: 1 cycle to `drive` = 0 and `busy` = 0.

## Configuration
- Macro: `BUZZER_TONE_EN`.
- Defined (passive buzzer):
  - during ON, `drive` is a square wave starting high on the first ON cycle and toggling every TONE_HALF cycles;
  - the tone counter restarts at every ON entry;
  - `drive` = 0 in IDLE and OFF.
- Undefined (active buzzer or LED): `drive` is held steady at 1 throughout ON. TONE_HALF is unused and the tone counter is not synthesized.

## Structure
- Shared package holds:
  - state encoding constants S_IDLE = 2'd0, S_ON = 2'd1, S_OFF = 2'd2;
  - default timing constants for 25 MHz (100 ms beep, 100 ms gap, 1 kHz tone).
- One sub-module, `buzzer_tone_gen`: tone half-period counter with toggle output and a synchronous restart input. It is instantiated only under `BUZZER_TONE_EN`.

## Test plan
Benches use ON_CYCLES = 4, OFF_CYCLES = 3 and TONE_HALF = 1 unless stated.
- Reset, then `start` with `beep_count` = 3 (macro off) -> `drive` pattern 1111 000 1111 000 1111; `busy` high for 18 cycles; `done` = 1 in cycle 19 with `busy` = 0.
- `start` with `beep_count` = 0 -> `done` high 1 cycle later; `busy` and `drive` stay 0.
- `start` again with `beep_count` = 5 while busy with a 2-beep train -> second request ignored; exactly 2 beeps played and a single `done`.
- `stop` in the 2nd cycle of the first OFF gap of a 3-beep train -> `drive` and `busy` = 0 next cycle; no `done`; a new `start` is then accepted normally.
- `start` asserted exactly in the `done` cycle -> new train starts with `drive` high on the next cycle; `start` and `stop` together in IDLE -> ignored.
- `BUZZER_TONE_EN` defined, `beep_count` = 1 -> `drive` = 1,0,1,0 over the 4 ON cycles, then 0; `rst_n` = 1 in the 2nd ON cycle -> all outputs 0 on the next edge.
